// File: rtl/rtc_calendar_counter.sv
// Real-time clock/calendar with 1 Hz prescaler, leap-year day counts and a
// two-button set-mode FSM. Define RTC_BLINK_EN to blink the field being edited.
module rtc_calendar_counter #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BLINK_DIV     = CLK_FREQ / 4,
  parameter logic [6:0]  RESET_YEAR_TH = 7'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] cnt_s,
  output logic [5:0] cnt_mi,
  output logic [5:0] cnt_h,
  output logic [5:0] cnt_d,
  output logic [5:0] cnt_mo,
  output logic [6:0] cnt_y_ten_unit,
  output logic [6:0] cnt_y_thousand_hundred,
  output logic       enable_s,
  output logic       enable_mi,
  output logic       enable_h,
  output logic       enable_d,
  output logic       enable_mo,
  output logic       enable_y,
  output logic       tick_1hz
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);

  typedef enum logic [2:0] {RUN, SET_Y, SET_MO, SET_D, SET_H, SET_MI, SET_S} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [5:0]    s_q, s_d, mi_q, mi_d, h_q, h_d, d_q, d_d, mo_q, mo_d;
  logic [6:0]    tu_q, tu_d, th_q, th_d;
  logic [5:0]    dim_q, dim_new;

  // Year-div-100 multiple of 4 covers the centuries; otherwise TU decides.
  function automatic logic [5:0] days_in_month(input logic [5:0] mo,
                                               input logic [6:0] tu,
                                               input logic [6:0] th);
    logic leap;
    leap = (tu != 7'd0) ? (tu[1:0] == 2'b00) : (th[1:0] == 2'b00);
    case (mo)
      6'd2:                     return leap ? 6'd29 : 6'd28;
      6'd4, 6'd6, 6'd9, 6'd11:  return 6'd30;
      default:                  return 6'd31;
    endcase
  endfunction

  function automatic logic [13:0] year_inc(input logic [6:0] th, input logic [6:0] tu);
    if (tu != 7'd99)      return {th, tu + 7'd1};
    else if (th != 7'd99) return {th + 7'd1, 7'd0};
    else                  return '0;
  endfunction

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    s_d  = s_q;  mi_d = mi_q; h_d  = h_q;
    d_d  = d_q;  mo_d = mo_q; tu_d = tu_q; th_d = th_q;
    dim_q   = days_in_month(mo_q, tu_q, th_q);
    dim_new = dim_q;

    if (state_q == RUN) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (s_q != 6'd59) s_d = s_q + 6'd1;
        else begin
          s_d = '0;
          if (mi_q != 6'd59) mi_d = mi_q + 6'd1;
          else begin
            mi_d = '0;
            if (h_q != 6'd23) h_d = h_q + 6'd1;
            else begin
              h_d = '0;
              if (d_q != dim_q) d_d = d_q + 6'd1;
              else begin
                d_d = 6'd1;
                if (mo_q != 6'd12) mo_d = mo_q + 6'd1;
                else begin
                  mo_d         = 6'd1;
                  {th_d, tu_d} = year_inc(th_q, tu_q);
                end
              end
            end
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    // btn_mode takes priority; a coincident btn_inc is dropped.
    if (btn_mode) begin
      case (state_q)
        RUN:     state_d = SET_Y;
        SET_Y:   state_d = SET_MO;
        SET_MO:  state_d = SET_D;
        SET_D:   state_d = SET_H;
        SET_H:   state_d = SET_MI;
        SET_MI:  state_d = SET_S;
        default: begin state_d = RUN; pre_d = '0; end
      endcase
    end else if (btn_inc) begin
      case (state_q)
        SET_Y: begin
          {th_d, tu_d} = year_inc(th_q, tu_q);
          dim_new      = days_in_month(mo_q, tu_d, th_d);
          if (d_q > dim_new) d_d = dim_new;
        end
        SET_MO: begin
          mo_d    = (mo_q == 6'd12) ? 6'd1 : mo_q + 6'd1;
          dim_new = days_in_month(mo_d, tu_q, th_q);
          if (d_q > dim_new) d_d = dim_new;
        end
        SET_D:   d_d  = (d_q >= dim_q) ? 6'd1 : d_q + 6'd1;
        SET_H:   h_d  = (h_q == 6'd23) ? '0 : h_q + 6'd1;
        SET_MI:  mi_d = (mi_q == 6'd59) ? '0 : mi_q + 6'd1;
        SET_S:   s_d  = (s_q == 6'd59) ? '0 : s_q + 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      s_q  <= '0;   mi_q <= '0;   h_q  <= '0;
      d_q  <= 6'd1; mo_q <= 6'd1;
      tu_q <= '0;   th_q <= RESET_YEAR_TH;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      s_q  <= s_d;  mi_q <= mi_d; h_q  <= h_d;
      d_q  <= d_d;  mo_q <= mo_d;
      tu_q <= tu_d; th_q <= th_d;
    end
  end

  assign cnt_s                  = s_q;
  assign cnt_mi                 = mi_q;
  assign cnt_h                  = h_q;
  assign cnt_d                  = d_q;
  assign cnt_mo                 = mo_q;
  assign cnt_y_ten_unit         = tu_q;
  assign cnt_y_thousand_hundred = th_q;
  assign tick_1hz               = tick_q;

`ifdef RTC_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [5:0]    en_q, en_d;

  // Enables are computed from next-state values so the flop output lines up
  // with the state it belongs to.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_d != RUN && state_d == state_q) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
      end
    end
    en_d = '1;
    case (state_d)
      SET_Y:   en_d[5] = ~blink_d;
      SET_MO:  en_d[4] = ~blink_d;
      SET_D:   en_d[3] = ~blink_d;
      SET_H:   en_d[2] = ~blink_d;
      SET_MI:  en_d[1] = ~blink_d;
      SET_S:   en_d[0] = ~blink_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      en_q        <= '1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      en_q        <= en_d;
    end
  end

  assign {enable_y, enable_mo, enable_d, enable_h, enable_mi, enable_s} = en_q;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_DIV;
  assign {enable_y, enable_mo, enable_d, enable_h, enable_mi, enable_s} = '1;
`endif

endmodule
